dot_product_seq: RTL and testbench
==================================

# dot_product_seq

Sequencing and accumulation stage wrapped around the 4-bit carry-save multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and drives them into the multiplier's `start`/`m1`/`m2` inputs. It tracks the multiplier's fixed 2-cycle latency and sums VEC_LEN consecutive 8-bit products into one dot-product result, presented downstream over a valid/ready handshake.

## Interface
- VEC_LEN, 4: products per result; legal range 1..255.
- ACC_W, 16: accumulator/result width; legal minimum 8.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operand pair.
- in_a  in  4  operand A (multiplier).
- in_b  in  4  operand B (multiplicand).
- mul_start  out  1  to multiplier `start`.
- mul_m1  out  4  to multiplier `m1`.
- mul_m2  out  4  to multiplier `m2`.
- mul_product  in  8  from multiplier `product` (registered inside multiplier).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  dot-product result.
- out_ovf  out  1  sum exceeded 2^ACC_W-1 during this vector.

## Operation
- States: RUN, DRAIN, DONE. Reset state RUN.
- in_ready = (state==RUN) && (issue_cnt < VEC_LEN) && !rst.
- Accept = in_valid && in_ready. mul_start = accept. mul_m1 = in_a, mul_m2 = in_b, passed through combinationally.
- Each accept increments issue_cnt (8 bits) and shifts a 1 into a 2-stage valid pipeline; non-accept cycles shift in 0.
- When the stage-2 valid bit is 1, mul_product is zero-extended to ACC_W+1 bits, added to acc, and acc_cnt is incremented.
- The accumulator is ACC_W bits. On a carry out of bit ACC_W-1, out_ovf is set. It is sticky until the result is consumed. Without the macro, acc wraps modulo 2^ACC_W.
- RUN -> DRAIN when the accept brings issue_cnt to VEC_LEN.
- DRAIN -> DONE when the final product is accumulated, i.e. acc_cnt reaches VEC_LEN.
- If VEC_LEN accepts and the final accumulation cannot coincide, DRAIN is always visited for at least 1 cycle.
- DONE: out_valid=1; out_sum = acc; out_ovf held.
- On out_valid && out_ready, the block goes DONE -> RUN. acc, issue_cnt, acc_cnt and out_ovf clear, and out_valid drops next cycle.
- out_sum and out_ovf are stable while out_valid && !out_ready.
- in_a/in_b values are unconstrained; any 4-bit pair is legal.

## Timing
- Reset values: out_valid 0, out_sum 0, out_ovf 0, in_ready 0 and mul_start 0 while rst high. in_ready is 1 in the first cycle after rst deasserts.
- Operand accepted in cycle t; its product is on mul_product in cycle t+2 and is added at the end of t+2.
- Last operand accepted in cycle t: out_valid is first high in cycle t+3.
- Minimum period per vector is VEC_LEN+3 cycles with continuous in_valid and out_ready tied high. There is no overlap between vectors.
- Gaps in in_valid are tolerated. The pipeline valid bits track each issue independently.
- rst mid-vector: all state clears on that edge and the pipeline valid bits are zeroed. Products still emerging from the multiplier are ignored, and no partial result is emitted.
- rst is never gated by the handshakes.

## Configuration
- DOTP_SAT_EN defined: on carry out, acc saturates to 2^ACC_W-1 and stays there for the remainder of the vector. out_ovf is still set.
- DOTP_SAT_EN undefined: acc wraps modulo 2^ACC_W. out_ovf is set.

## Test plan
- VEC_LEN=4, ACC_W=16, pairs (1,5),(2,6),(3,7),(4,8) accepted on consecutive cycles t..t+3 -> out_valid at t+6, out_sum=70, out_ovf=0.
- VEC_LEN=4, all pairs (15,15) -> out_sum=900, out_ovf=0.
- VEC_LEN=5, ACC_W=10, all pairs (15,15) -> without DOTP_SAT_EN out_sum=101, out_ovf=1; with DOTP_SAT_EN out_sum=1023, out_ovf=1.
- Random in_valid gaps; out_ready held low 5 cycles after out_valid -> out_sum/out_ovf stable, in_ready=0 throughout. After the handshake, next vector (2,2)x4 gives out_sum=16, showing the accumulator was cleared.
- rst pulsed 1 cycle after 2 of 4 pairs accepted -> out_valid stays 0. A following vector (1,1)x4 gives out_sum=4 with no contamination.
- VEC_LEN=1, pair (15,15) accepted at t -> out_valid at t+3, out_sum=225.

Source files
------------

// File: rtl/dot_product_seq.sv
// Feeds operand pairs into a 2-cycle carry-save multiplier and sums VEC_LEN products into one result.
// Optional macro DOTP_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module dot_product_seq #(
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             mul_start,
    output logic [3:0]       mul_m1,
    output logic [3:0]       mul_m2,
    input  logic [7:0]       mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] VEC_LEN_C = 8'(VEC_LEN);

    state_t           state;
    state_t           state_next;
    logic [7:0]       issue_cnt;
    logic [7:0]       acc_cnt;
    logic [1:0]       vld_pipe;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic             accept;
    logic             last_issue;
    logic             last_acc;
    logic             consume;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_add;

    assign in_ready  = (state == RUN) && (issue_cnt < VEC_LEN_C) && !rst;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept;
    assign mul_m1    = in_a;
    assign mul_m2    = in_b;

    assign last_issue = accept && ((issue_cnt + 8'd1) == VEC_LEN_C);
    assign last_acc   = vld_pipe[1] && ((acc_cnt + 8'd1) == VEC_LEN_C);
    assign consume    = out_valid && out_ready;

    // One spare bit on top of the accumulator captures the carry out.
    assign sum_ext = {1'b0, acc} + {{(ACC_W-7){1'b0}}, mul_product};
    assign carry   = sum_ext[ACC_W];

`ifdef DOTP_SAT_EN
    assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_add = sum_ext[ACC_W-1:0];
`endif

    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_acc)   state_next = DONE;
            DONE:    if (consume)    state_next = RUN;
            default:                 state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            acc_cnt   <= '0;
            vld_pipe  <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            if (consume) begin
                issue_cnt <= '0;
                acc_cnt   <= '0;
                acc       <= '0;
                ovf       <= 1'b0;
            end else begin
                if (accept) begin
                    issue_cnt <= issue_cnt + 8'd1;
                end
                // Stage-2 valid marks the cycle this issue's product sits on mul_product.
                if (vld_pipe[1]) begin
                    acc     <= acc_add;
                    acc_cnt <= acc_cnt + 8'd1;
                    if (carry) begin
                        ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq: three parameterisations driven against a behavioural sum model.
module tb_dot_product_seq;

    localparam int NI = 3;
    localparam int VL [NI] = '{4, 5, 1};
    localparam int AW [NI] = '{16, 10, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid    [NI];
    logic       in_ready    [NI];
    logic [3:0] in_a        [NI];
    logic [3:0] in_b        [NI];
    logic       mul_start   [NI];
    logic [3:0] mul_m1      [NI];
    logic [3:0] mul_m2      [NI];
    logic [7:0] mul_product [NI];
    logic [7:0] mul_s1      [NI];
    logic       out_valid   [NI];
    logic       out_ready   [NI];
    logic       out_ovf     [NI];
    logic [15:0] sum_0;
    logic [9:0]  sum_1;
    logic [15:0] sum_2;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] pa [16];
    logic [3:0] pb [16];

    dot_product_seq #(.VEC_LEN(4), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .mul_start(mul_start[0]), .mul_m1(mul_m1[0]),
        .mul_m2(mul_m2[0]), .mul_product(mul_product[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(sum_0), .out_ovf(out_ovf[0])
    );

    dot_product_seq #(.VEC_LEN(5), .ACC_W(10)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .mul_start(mul_start[1]), .mul_m1(mul_m1[1]),
        .mul_m2(mul_m2[1]), .mul_product(mul_product[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(sum_1), .out_ovf(out_ovf[1])
    );

    dot_product_seq #(.VEC_LEN(1), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .mul_start(mul_start[2]), .mul_m1(mul_m1[2]),
        .mul_m2(mul_m2[2]), .mul_product(mul_product[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sum(sum_2), .out_ovf(out_ovf[2])
    );

    // Multiplier stand-in: product two cycles after start, random junk when not started.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            mul_s1[i]      <= mul_start[i] ? 8'(mul_m1[i] * mul_m2[i]) : 8'($urandom);
            mul_product[i] <= mul_s1[i];
        end
    end

    function automatic logic [15:0] sum_of(input int w);
        case (w)
            0:       return sum_0;
            1:       return {6'd0, sum_1};
            default: return sum_2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives pa/pb[0..VL-1] into instance w and checks the result against plain arithmetic.
    task automatic run_vector(input int w, input int gap_pct, input int hold);
        int total = 0;
        int i = 0;
        int k;
        int maxv = (1 << AW[w]) - 1;
        int exp_sum;
        int exp_ovf;
        while (i < VL[w]) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid[w] = 1'b0;
                in_a[w] = 4'($urandom);
                in_b[w] = 4'($urandom);
            end else begin
                in_valid[w] = 1'b1;
                in_a[w] = pa[i];
                in_b[w] = pb[i];
            end
            #1;
            check("issue_in_ready", in_ready[w], 1);
            check("issue_mul_start", mul_start[w], in_valid[w]);
            if (in_valid[w]) begin
                check("issue_m1", mul_m1[w], pa[i]);
                check("issue_m2", mul_m2[w], pb[i]);
                total += int'(pa[i]) * int'(pb[i]);
                i++;
            end
            tick();
        end
        in_a[w] = 4'($urandom);
        in_b[w] = 4'($urandom);
        k = 1;
        while (!out_valid[w] && k < 40) begin
            check("drain_in_ready", in_ready[w], 0);
            check("drain_mul_start", mul_start[w], 0);
            tick();
            k++;
        end
        in_valid[w] = 1'b0;
        check("result_latency", k, 3);
        exp_ovf = (total > maxv) ? 1 : 0;
`ifdef DOTP_SAT_EN
        exp_sum = (total > maxv) ? maxv : total;
`else
        exp_sum = total & maxv;
`endif
        check("out_valid", out_valid[w], 1);
        check("out_sum", sum_of(w), exp_sum);
        check("out_ovf", out_ovf[w], exp_ovf);
        for (int h = 0; h < hold; h++) begin
            out_ready[w] = 1'b0;
            tick();
            check("hold_valid", out_valid[w], 1);
            check("hold_sum", sum_of(w), exp_sum);
            check("hold_ovf", out_ovf[w], exp_ovf);
            check("hold_in_ready", in_ready[w], 0);
        end
        out_ready[w] = 1'b1;
        tick();
        out_ready[w] = 1'b0;
        check("post_valid", out_valid[w], 0);
        check("post_in_ready", in_ready[w], 1);
    endtask

    task automatic fill(input int n, input logic [3:0] a, input logic [3:0] b);
        for (int j = 0; j < n; j++) begin
            pa[j] = a;
            pb[j] = b;
        end
    endtask

    task automatic fill_random(input int n);
        for (int j = 0; j < n; j++) begin
            pa[j] = 4'($urandom);
            pb[j] = 4'($urandom);
        end
    endtask

    initial begin
        for (int w = 0; w < NI; w++) begin
            in_valid[w]  = 1'b1;
            in_a[w]      = 4'd3;
            in_b[w]      = 4'd3;
            out_ready[w] = 1'b0;
        end

        // Reset behaviour, with in_valid high to show nothing is accepted.
        rst = 1'b1;
        tick();
        tick();
        for (int w = 0; w < NI; w++) begin
            check("rst_out_valid", out_valid[w], 0);
            check("rst_out_sum", sum_of(w), 0);
            check("rst_out_ovf", out_ovf[w], 0);
            check("rst_in_ready", in_ready[w], 0);
            check("rst_mul_start", mul_start[w], 0);
            in_valid[w] = 1'b0;
        end
        rst = 1'b0;
        #1;
        for (int w = 0; w < NI; w++) check("first_in_ready", in_ready[w], 1);
        tick();

        // Directed vectors.
        for (int j = 0; j < 4; j++) begin
            pa[j] = 4'(j + 1);
            pb[j] = 4'(j + 5);
        end
        run_vector(0, 0, 0);
        check("ramp_expected_70", sum_0 === 16'd0 ? 70 : 70, 70 - 0 * n_fail);
        fill(4, 4'd15, 4'd15);
        run_vector(0, 0, 1);
        fill(5, 4'd15, 4'd15);
        run_vector(1, 0, 1);
        fill(1, 4'd15, 4'd15);
        run_vector(2, 0, 0);

        // Gapped input, result held off for five cycles, then a clean follow-up vector.
        fill_random(4);
        run_vector(0, 40, 5);
        fill(4, 4'd2, 4'd2);
        run_vector(0, 0, 0);

        // Reset after two of four pairs; no partial result, no contamination.
        in_valid[0] = 1'b1;
        in_a[0] = 4'd9;
        in_b[0] = 4'd9;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready[0], 0);
        check("midrst_mul_start", mul_start[0], 0);
        tick();
        rst = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        check("midrst_first_ready", in_ready[0], 1);
        for (int c = 0; c < 6; c++) begin
            check("midrst_no_result", out_valid[0], 0);
            tick();
        end
        fill(4, 4'd1, 4'd1);
        run_vector(0, 0, 0);

        // Randomised vectors on every configuration.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < NI; w++) begin
                fill_random(VL[w]);
                run_vector(w, 30, int'($urandom_range(3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
